// File: rtl/intersection_scheduler.sv
// intersection_scheduler: demand-driven NS/EW/pedestrian phase arbiter with yellow and all-red clearance.
// Define EMERGENCY_PREEMPT_EN to enable emergency preemption via emg_req/emg_dir.
module intersection_scheduler #(
  parameter int TW     = 8,
  parameter int MIN_G  = 8,
  parameter int MAX_G  = 20,
  parameter int YEL    = 3,
  parameter int ALLRED = 2,
  parameter int WALK_T = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [1:0] NS,
  output logic [1:0] EW,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase,
  output logic       emg_active
);
  typedef enum logic [2:0] {
    NS_G = 3'd0, NS_Y = 3'd1, CLR = 3'd2, EW_G = 3'd3, EW_Y = 3'd4, WALK = 3'd5, CLR2 = 3'd6
  } state_t;
  localparam logic [TW-1:0] T_MING = TW'(MIN_G - 1);
  localparam logic [TW-1:0] T_MAXG = TW'(MAX_G - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YEL - 1);
  localparam logic [TW-1:0] T_ALLR = TW'(ALLRED - 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK_T - 1);
  localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          last_dir_q, last_dir_d;
  logic          ped_pend_q, ped_pend_d;
  logic          emg_q;
  logic          emg, emg_ew, go_ns, go_ew;
  state_t        grant;
`ifdef EMERGENCY_PREEMPT_EN
  assign emg    = emg_req;
  assign emg_ew = emg_dir;
`else
  assign emg    = 1'b0;
  assign emg_ew = 1'b0;
  wire unused_emg = &{1'b0, emg_req, emg_dir};
`endif
  // Preemption toward own side holds green; toward the other side forces yellow at once.
  assign go_ns = emg ? emg_ew
                     : (timer_q >= T_MING) && (ew_car || ped_pend_q) && (!ns_car || timer_q >= T_MAXG);
  assign go_ew = emg ? !emg_ew
                     : (timer_q >= T_MING) && (ns_car || ped_pend_q) && (!ew_car || timer_q >= T_MAXG);
  assign grant = emg ? (emg_ew ? EW_G : NS_G) : (last_dir_q ? NS_G : EW_G);
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      NS_G: state_d = go_ns ? NS_Y : NS_G;
      EW_G: state_d = go_ew ? EW_Y : EW_G;
      NS_Y: if (timer_q == T_YEL) begin
        state_d    = CLR;
        last_dir_d = 1'b0;
      end
      EW_Y: if (timer_q == T_YEL) begin
        state_d    = CLR;
        last_dir_d = 1'b1;
      end
      CLR:  state_d = (timer_q == T_ALLR) ? ((ped_pend_q && !emg) ? WALK : grant) : CLR;
      WALK: state_d = (emg || timer_q == T_WALK) ? CLR2 : WALK;
      CLR2: state_d = (timer_q == T_ALLR) ? grant : CLR2;
      default: state_d = CLR;
    endcase
  end
  assign timer_d    = (state_d != state_q) ? '0 : (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
  // A press on the very cycle WALK is entered survives into the next request.
  assign ped_pend_d = ped_req || (ped_pend_q && !(state_d == WALK && state_q != WALK));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= NS_G;
      timer_q    <= '0;
      last_dir_q <= 1'b0;
      ped_pend_q <= 1'b0;
      emg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
      ped_pend_q <= ped_pend_d;
      emg_q      <= emg;
    end
  end
  assign NS         = (state_q == NS_G) ? 2'b10 : (state_q == NS_Y) ? 2'b01 : 2'b00;
  assign EW         = (state_q == EW_G) ? 2'b10 : (state_q == EW_Y) ? 2'b01 : 2'b00;
  assign walk       = (state_q == WALK);
  assign ped_pend   = ped_pend_q;
  assign phase      = state_q;
  assign emg_active = emg_q;
endmodule
